// File: rtl/l2_response_queue_pkg.sv
// Shared L2 response definitions: the response packet and its type enum.
// Used by the response queue, its interface and anything that builds packets.
package l2_response_queue_pkg;

   typedef enum logic [1:0] {
      RSP_LOAD       = 2'd0,
      RSP_STORE      = 2'd1,
      RSP_FLUSH      = 2'd2,
      RSP_INVALIDATE = 2'd3
   } l2rsp_type_t;

   typedef struct packed {
      logic        status;
      logic [1:0]  core;
      logic [7:0]  id;
      l2rsp_type_t packet_type;
      logic        cache_type;
      logic [31:0] data;
      logic [31:0] address;
   } l2rsp_packet_t;

endpackage

// File: rtl/l2_response_queue_if.sv
// Bundle between the L2 update stage, the response queue and the core-side consumer.
// The slave modport is the queue itself; the master modport is the surrounding environment.
interface l2_response_queue_if
   import l2_response_queue_pkg::*;
#(
   parameter int DEPTH = 8
) ();

   logic                     l2_response_valid;
   l2rsp_packet_t            l2_response;
   logic                     rq_response_valid;
   l2rsp_packet_t            rq_response;
   logic                     rq_response_ready;
   logic                     rq_almost_full;
   logic                     rq_overflow;
   logic [$clog2(DEPTH):0]   rq_count;

   modport slave (
      input  l2_response_valid, l2_response, rq_response_ready,
      output rq_response_valid, rq_response, rq_almost_full, rq_overflow, rq_count
   );

   modport master (
      output l2_response_valid, l2_response, rq_response_ready,
      input  rq_response_valid, rq_response, rq_almost_full, rq_overflow, rq_count
   );

endinterface

// File: rtl/l2_response_queue_fifo.sv
// Plain synchronous FIFO: flop storage, wrapping pointers and an occupancy count.
// Push and pop arrive pre-qualified; the caller decides what may be accepted.
module l2_response_queue_fifo
   import l2_response_queue_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  l2rsp_packet_t            wr_data,
   output l2rsp_packet_t            rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic [$clog2(DEPTH):0]   count_next
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   l2rsp_packet_t    mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   assign rd_data = mem[rd_ptr];

   always_comb begin
      count_next = count + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // DEPTH is a power of two, so pointer overflow is the wrap
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/l2_response_queue.sv
// Response queue behind the L2 update stage: buffers unthrottled response pulses,
// hands them to the core over valid/ready, and warns the arbiter before it fills.
module l2_response_queue
   import l2_response_queue_pkg::*;
#(
   parameter int DEPTH              = 8,
   parameter int ALMOST_FULL_MARGIN = 4
) (
   input logic            clk,
   input logic            reset,
   l2_response_queue_if.slave bus
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic             head_valid;
   logic             full;
   logic             pop;
   logic             push_ok;
   logic             drop;

   assign head_valid = (count != '0);
   assign full       = (count == CNT_W'(DEPTH));
   assign pop        = head_valid && bus.rq_response_ready;
   // A pop at full frees the slot the incoming push lands in
   assign push_ok    = bus.l2_response_valid && (!full || pop);
   assign drop       = bus.l2_response_valid && full && !pop;

   l2_response_queue_fifo #(
      .DEPTH (DEPTH)
   ) fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push_ok),
      .pop        (pop),
      .wr_data    (bus.l2_response),
      .rd_data    (bus.rq_response),
      .count      (count),
      .count_next (count_next)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.rq_almost_full <= 1'b0;
         bus.rq_overflow    <= 1'b0;
      end else begin
         bus.rq_almost_full <= (count_next >= CNT_W'(DEPTH - ALMOST_FULL_MARGIN));
         if (drop) bus.rq_overflow <= 1'b1;
      end
   end

   assign bus.rq_response_valid = head_valid;
   assign bus.rq_count          = count;

   // Losing a response means the arbiter ignored almost-full
   always @(posedge clk) begin
      if (!reset) begin
         assert (!drop)
         else $warning("l2_response_queue: response dropped, queue full at %0t", $time);
      end
   end

endmodule

// File: doc/l2_response_queue.md
Name: l2_response_queue

Overview:
- Sits directly downstream of the L2 update stage.
- Captures every single-cycle response pulse (l2rsp_packet_t) that the update stage emits without backpressure, and buffers it in a FIFO.
- Delivers responses to the core-side consumer over a valid/ready handshake.
- Raises a registered almost-full signal so the L2 request arbiter can stop issuing new requests while responses already in flight still have room.

Parameters:
- DEPTH, 8, number of buffered response entries; power of two, >= 2.
- ALMOST_FULL_MARGIN, 4, free-slot threshold; covers the L2 pipeline depth in flight. Must be < DEPTH.

Ports:
- clk  input  1  clock
- reset  input  1  reset
- l2_response_valid  input  1  response pulse from update stage
- l2_response  input  l2rsp_packet_t  response packet from update stage
- rq_response_valid  output  1  head entry available to consumer
- rq_response  output  l2rsp_packet_t  head entry
- rq_response_ready  input  1  consumer accepts head this cycle
- rq_almost_full  output  1  to L2 arbiter; stall new requests
- rq_overflow  output  1  sticky; a response was dropped
- rq_count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset is asynchronous, active-high, clock clk.
  - Reset clears read/write pointers, count, rq_response_valid, rq_almost_full and rq_overflow to 0.
  - Storage array is not reset.
  - Reset mid-operation discards all entries; the first response after deassertion is captured normally.
- Push: l2_response_valid=1 at a rising edge writes l2_response to mem[wr_ptr]. wr_ptr increments modulo DEPTH (natural wrap, $clog2(DEPTH) bits).
- Pop: rq_response_valid && rq_response_ready at a rising edge advances rd_ptr modulo DEPTH.
- rq_response is mem[rd_ptr], a combinational read of the flop array.
- rq_response_valid = (count != 0), driven from a registered count.
- Latency: a push at edge N into an empty queue gives rq_response_valid=1 in the cycle after edge N. There is no same-cycle bypass.
- Count:
  - count_next = count + push_accepted - pop.
  - Width $clog2(DEPTH)+1, so count reaches DEPTH without aliasing.
- Simultaneous push and pop:
  - Not full: both occur and count is unchanged.
  - Full (count==DEPTH): the push is accepted because the pop frees a slot; count stays DEPTH.
  - Empty: pop is impossible because valid=0; the push proceeds and count becomes 1.
- Overflow: a push with count==DEPTH and no pop is dropped.
  - Pointers and count are unchanged.
  - rq_overflow is set and stays 1 until reset.
  - A simulation assertion fires; this is a design error, since the arbiter must honour almost-full.
- Handshake rules:
  - Consumer may hold rq_response_ready high continuously.
  - Head data stays stable while valid && !ready.
  - Ready while !valid has no effect.
- rq_almost_full: registered, computed from count_next.
  - 1 when count_next >= DEPTH - ALMOST_FULL_MARGIN, else 0.
  - Deasserts the cycle after count drops below the threshold.
- Packet contents pass through unmodified: status, core, id, packet_type, cache_type, data, address.

Decomposition:
- l2rsp_packet_t and the response type enum remain in the shared defines package.
- No new package types. DEPTH and ALMOST_FULL_MARGIN stay as module parameters.
- Optional sub-module: generic sync_fifo (storage + pointers + count); the top adds overflow and almost-full logic.
- A single flat module is also acceptable at this size.

Test Plan:
- Single push: push packet id=3, core=1 with ready=0 → next cycle valid=1, rq_response.id=3, rq_count=1. Raise ready → valid=0 the following cycle, count=0.
- Fill and threshold (DEPTH=8, margin=4), ready=0: push 4 packets → rq_almost_full=1 after the 4th edge, count=4. Push 4 more → count=8. Drain 1 → almost_full stays 1 (count 7); drain to 3 → almost_full=0.
- Ordering/wrap: stream 20 packets with ids 0..19, ready toggling 1/0 every cycle → output ids exactly 0..19 in order, no gaps, pointers wrap twice.
- Full with simultaneous push/pop: at count=8, push id=42 with ready=1 → count stays 8, rq_overflow=0, id 42 emerges eighth.
- Overflow: at count=8, ready=0, push id=99 → count stays 8, rq_overflow=1 and sticky, assertion fires, id 99 never appears.
- Reset mid-operation: count=5, assert reset for one cycle → valid=0, count=0, almost_full=0, overflow=0. The next push appears with count=1.
